// File: rtl/mulu_seq.sv
// mulu_seq: sequential unsigned shift-add multiplier.
// Takes two W-bit operands when start is seen in IDLE, consumes one multiplier
// bit per clock for W clocks, then presents a registered 2W-bit product
// together with a single-cycle done pulse.

module mulu_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   multiplicand,
    input  logic [W-1:0]   multiplier,
    output logic [2*W-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [2*W:0]    acc_q;
    logic [2*W:0]    acc_d;
    logic [W-1:0]    mreg_q;
    logic [CW-1:0]   cnt_q;
    logic [W:0]      sum_d;
    logic [2*W-1:0]  product_q;
    logic            busy_q;
    logic            done_q;

    // One iteration: add the multiplicand into the upper half when the current
    // multiplier bit is set, keeping the carry, then shift the whole accumulator right.
    always_comb begin
        sum_d = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mreg_q} : {(W+1){1'b0}});
        acc_d = {1'b0, sum_d, acc_q[W-1:1]};
    end

    // Control FSM plus datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mreg_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q   <= {1'b0, {W{1'b0}}, multiplier};
                        mreg_q  <= multiplicand;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        product_q <= acc_d[2*W-1:0];
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mulu_seq.sv
// tb_mulu_seq: scoreboard bench for mulu_seq. The stimulus side pushes the
// hand-computed product for every accepted request; a monitor pops and compares
// whenever done is seen.

module tb_mulu_seq;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    logic           start4 = 1'b0;
    logic [3:0]     a4 = '0;
    logic [3:0]     b4 = '0;
    logic [7:0]     product4;
    logic           busy4;
    logic           done4;

    int errors = 0;
    int checks = 0;
    logic [2*W-1:0] expQ[$];
    logic prevDone = 1'b0;

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    mulu_seq #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .product(product), .busy(busy), .done(done)
    );

    mulu_seq #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .multiplicand(a4), .multiplier(b4),
        .product(product4), .busy(busy4), .done(done4)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            checkOutput("done_single_cycle", prevDone, 0);
            checkOutput("done_has_pending_request", expQ.size() > 0, 1);
            if (expQ.size() > 0)
                checkOutput("product", product, expQ.pop_front());
        end
        prevDone = done;
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
        @(posedge clk);
        #1;
        start = 1'b1;
        multiplicand = a;
        multiplier = b;
        expQ.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int cycles, output int busyCycles);
        bit found;
        found = 1'b0;
        cycles = 0;
        busyCycles = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            cycles++;
            if (done) found = 1'b1;
            else if (busy) busyCycles++;
        end
        checkOutput("done_seen", found, 1);
        if (found) checkOutput("busy_low_in_done", busy, 0);
    endtask

    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
        int c;
        int bc;
        applyStimulus(a, b, exp);
        waitDone(c, bc);
        checkOutput("latency", c, W + 1);
        checkOutput("busy_cycles", bc, W);
        @(negedge clk);
        checkOutput("product_hold", product, exp);
        checkOutput("done_dropped", done, 0);
    endtask

    initial begin
        int c;
        int bc;
        int cnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        $display("[TB] start");
        @(negedge clk);
        checkOutput("reset_product", product, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        #12 rst_n = 1'b1;

        // Basic and boundary products
        runOp(8'd13, 8'd11, 16'h008F);
        runOp(8'd255, 8'd255, 16'hFE01);
        runOp(8'd255, 8'd1, 16'h00FF);
        runOp(8'd0, 8'd200, 16'h0000);
        runOp(8'd200, 8'd0, 16'h0000);

        // A second start during RUN with changed operands is ignored
        applyStimulus(8'd6, 8'd7, 16'd42);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        multiplicand = 8'd9;
        multiplier = 8'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        multiplicand = 8'd1;
        multiplier = 8'd2;
        waitDone(c, bc);
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) cnt++;
        end
        checkOutput("no_second_op", cnt, 0);
        checkOutput("product_after_ignored_start", product, 16'd42);

        // Asynchronous reset in the middle of an operation
        applyStimulus(8'd100, 8'd50, 16'd5000);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("async_reset_product", product, 0);
        checkOutput("async_reset_busy", busy, 0);
        checkOutput("async_reset_done", done, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) cnt++;
        end
        checkOutput("no_done_after_reset", cnt, 0);
        runOp(8'd3, 8'd5, 16'd15);

        // start held high: back-to-back operations every W+2 cycles
        @(posedge clk);
        #1;
        start = 1'b1;
        multiplicand = 8'd2;
        multiplier = 8'd3;
        expQ.push_back(16'd6);
        waitDone(c, bc);
        multiplicand = 8'd4;
        multiplier = 8'd4;
        expQ.push_back(16'd16);
        waitDone(c, bc);
        checkOutput("held_start_period", c, W + 2);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("held_start_final_product", product, 16'd16);

        // Random regression against the exact product
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            runOp(ra, rb, 16'(ra * rb));
        end

        // Narrow instance, W=4
        @(posedge clk);
        #1;
        start4 = 1'b1;
        a4 = 4'd15;
        b4 = 4'd15;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        cnt = 0;
        c = 0;
        for (int i = 0; i < 20 && c == 0; i++) begin
            @(negedge clk);
            cnt++;
            if (done4) c = 1;
        end
        checkOutput("w4_done_seen", c, 1);
        checkOutput("w4_latency", cnt, 5);
        checkOutput("w4_product", product4, 8'd225);

        repeat (2) @(negedge clk);
        checkOutput("queue_empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
